// File: rtl/mips_ctrl_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the multi-cycle MIPS control unit:
// FSM state enum, opcode/funct encodings, ALU control codes, ALUOp codes,
// mux select codes and the datapath control bundle.
package mips_ctrl_pkg;

    localparam int unsigned STATE_W    = 4;
    localparam int unsigned OP_W       = 6;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned ALU_CODE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Per-state datapath control bundle (write strobes ungated by reset)
    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
    } ctrl_t;

endpackage

// File: rtl/mips_mc_alu_decoder.sv
`timescale 1ns/1ps
// ALU control decode: maps ALUOp and funct to the 3-bit ALU operation code.
// Ports: aluop (ALUOp class), funct (IR[5:0]), alu_ctl (ALU code),
//        funct_illegal (funct is not one of add/sub/and/or/slt).
module mips_mc_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluop_t                  aluop,
    input  logic [FUNCT_W-1:0]      funct,
    output logic [ALU_CODE_W-1:0]   alu_ctl,
    output logic                    funct_illegal
);

    logic [ALU_CODE_W-1:0] funct_ctl;

    // R-type funct table; unknown funct falls back to add
    always_comb begin
        funct_ctl     = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD:  funct_ctl = ALU_ADD;
            FN_SUB:  funct_ctl = ALU_SUB;
            FN_AND:  funct_ctl = ALU_AND;
            FN_OR:   funct_ctl = ALU_OR;
            FN_SLT:  funct_ctl = ALU_SLT;
            default: funct_illegal = 1'b1;
        endcase
    end

    // ALUOp selects fixed add/sub or the funct field
    always_comb begin
        alu_ctl = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   alu_ctl = ALU_SUB;
            ALUOP_FUNCT: alu_ctl = funct_ctl;
            default:     alu_ctl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
`timescale 1ns/1ps
// Moore control FSM for the multi-cycle MIPS core with ALU decode.
// Inputs : clk, reset (async active-low), op/funct (IR fields), zero (ALU flag),
//          mem_ready (memory access completes this cycle).
// Outputs: datapath enables/selects (pc_en, iord, mem_write, ir_write, reg_write,
//          mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_src, alu_control),
//          illegal_op (DECODE-cycle pulse), state_dbg (current state encoding).
module mips_mc_controller
    import mips_ctrl_pkg::*;
#(
    parameter bit          MEM_WAIT_EN = 1'b1,
    parameter bit          SUPPORT_BNE = 1'b1,
    parameter int unsigned ALUCTL_W    = 3
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_en,
    output logic                iord,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_src,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state_dbg
);

    state_t                state, state_nxt;
    aluop_t                aluop;
    ctrl_t                 ctrl;
    logic                  ready;
    logic                  pc_write;
    logic                  branch_en;
    logic                  dec_illegal;
    logic                  funct_illegal;
    logic [ALU_CODE_W-1:0] alu_ctl;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    mips_mc_alu_decoder u_alu_dec (
        .aluop         (aluop),
        .funct         (funct),
        .alu_ctl       (alu_ctl),
        .funct_illegal (funct_illegal)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Next-state and per-state control decode; unknown encodings fall to FETCH
    always_comb begin
        state_nxt   = S_FETCH;
        ctrl        = '0;
        aluop       = ALUOP_ADD;
        pc_write    = 1'b0;
        branch_en   = 1'b0;
        dec_illegal = 1'b0;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_src    = PCSRC_ALU;
                if (ready) begin
                    ctrl.ir_write = 1'b1;
                    pc_write      = 1'b1;
                    state_nxt     = S_DECODE;
                end else begin
                    state_nxt     = S_FETCH;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE: begin
                        state_nxt   = S_EXEC;
                        dec_illegal = funct_illegal;
                    end
                    OP_BEQ:  state_nxt = S_BRANCH;
                    OP_BNE: begin
                        if (SUPPORT_BNE) state_nxt   = S_BRANCH;
                        else             dec_illegal = 1'b1;
                    end
                    OP_ADDI: state_nxt = S_ADDIEX;
                    OP_J:    state_nxt = S_JUMP;
                    default: dec_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_nxt      = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
                state_nxt = ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                // strobe held through the whole wait, not just the completing cycle
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                state_nxt      = ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                aluop          = ALUOP_FUNCT;
                state_nxt      = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.pc_src    = PCSRC_ALUOUT;
                aluop          = ALUOP_SUB;
                branch_en      = (SUPPORT_BNE && (op == OP_BNE)) ? ~zero : zero;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_nxt      = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src = PCSRC_JUMP;
                pc_write    = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes are killed combinationally while reset is held low
    assign pc_en       = reset & (pc_write | branch_en);
    assign mem_write   = reset & ctrl.mem_write;
    assign ir_write    = reset & ctrl.ir_write;
    assign reg_write   = reset & ctrl.reg_write;
    assign illegal_op  = reset & dec_illegal;
    assign iord        = ctrl.iord;
    assign mem_to_reg  = ctrl.mem_to_reg;
    assign reg_dst     = ctrl.reg_dst;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign pc_src      = ctrl.pc_src;
    assign alu_control = ALUCTL_W'(alu_ctl);
    assign state_dbg   = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
`timescale 1ns/1ps
// Bench for mips_mc_controller. Instance 0: memory wait on, bne supported, 3-bit
// ALU control. Instance 1: memory wait off, bne illegal, 4-bit ALU control.
// Each instruction is expanded into its sequence of phases and the expected
// outputs per phase are checked every cycle.
module tb_mips_mc_controller;

    localparam int ND = 2;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3,
                   P_MEMWB = 4, P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7,
                   P_BRANCH = 8, P_ADDIEX = 9, P_ADDIWB = 10, P_JUMP = 11;

    string pname [12] = '{"FETCH", "DECODE", "MEMADR", "MEMRD", "MEMWB", "MEMWR",
                          "EXEC", "ALUWB", "BRANCH", "ADDIEX", "ADDIWB", "JUMP"};

    logic       clk = 1'b0;
    logic       reset [ND];
    logic [5:0] op [ND];
    logic [5:0] funct [ND];
    logic       zero [ND];
    logic       mem_ready [ND];
    logic       pc_en [ND], iord [ND], mem_write [ND], ir_write [ND];
    logic       reg_write [ND], mem_to_reg [ND], reg_dst [ND], alu_src_a [ND];
    logic [1:0] alu_src_b [ND], pc_src [ND];
    logic       illegal_op [ND];
    logic [3:0] state_dbg [ND];
    logic [2:0] alu_control_a;
    logic [3:0] alu_control_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_mc_controller #(.MEM_WAIT_EN(1'b1), .SUPPORT_BNE(1'b1), .ALUCTL_W(3)) u_dut_a (
        .clk(clk), .reset(reset[0]), .op(op[0]), .funct(funct[0]), .zero(zero[0]),
        .mem_ready(mem_ready[0]), .pc_en(pc_en[0]), .iord(iord[0]), .mem_write(mem_write[0]),
        .ir_write(ir_write[0]), .reg_write(reg_write[0]), .mem_to_reg(mem_to_reg[0]),
        .reg_dst(reg_dst[0]), .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]),
        .pc_src(pc_src[0]), .alu_control(alu_control_a), .illegal_op(illegal_op[0]),
        .state_dbg(state_dbg[0])
    );

    mips_mc_controller #(.MEM_WAIT_EN(1'b0), .SUPPORT_BNE(1'b0), .ALUCTL_W(4)) u_dut_b (
        .clk(clk), .reset(reset[1]), .op(op[1]), .funct(funct[1]), .zero(zero[1]),
        .mem_ready(mem_ready[1]), .pc_en(pc_en[1]), .iord(iord[1]), .mem_write(mem_write[1]),
        .ir_write(ir_write[1]), .reg_write(reg_write[1]), .mem_to_reg(mem_to_reg[1]),
        .reg_dst(reg_dst[1]), .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]),
        .pc_src(pc_src[1]), .alu_control(alu_control_b), .illegal_op(illegal_op[1]),
        .state_dbg(state_dbg[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Observed output vector, ALU control zero-extended to 4 bits
    function automatic logic [20:0] obs(input int d);
        logic [3:0] ac;
        ac = (d == 0) ? {1'b0, alu_control_a} : alu_control_b;
        return {pc_en[d], iord[d], mem_write[d], ir_write[d], reg_write[d], mem_to_reg[d],
                reg_dst[d], alu_src_a[d], alu_src_b[d], pc_src[d], ac, illegal_op[d], state_dbg[d]};
    endfunction

    function automatic logic [3:0] alu_ref(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    // Expected outputs for a phase of the instruction, from the control table
    function automatic logic [20:0] expect_vec(input int ph, input logic [5:0] o, input logic [5:0] f,
                                               input logic z, input logic rdy, input logic ill);
        logic pe, io, mw, irw, rw, m2r, rd, sa, il;
        logic [1:0] sb, ps;
        logic [3:0] ac;
        pe = 0; io = 0; mw = 0; irw = 0; rw = 0; m2r = 0; rd = 0; sa = 0; il = 0;
        sb = 2'b00; ps = 2'b00; ac = 4'b0010;
        case (ph)
            P_FETCH:            begin sb = 2'b01; irw = rdy; pe = rdy; end
            P_DECODE:           begin sb = 2'b11; il = ill; end
            P_MEMADR, P_ADDIEX: begin sa = 1; sb = 2'b10; end
            P_MEMRD:            io = 1;
            P_MEMWB:            begin rw = 1; m2r = 1; end
            P_MEMWR:            begin io = 1; mw = 1; end
            P_EXEC:             begin sa = 1; ac = alu_ref(f); end
            P_ALUWB:            begin rw = 1; rd = 1; end
            P_BRANCH:           begin sa = 1; ps = 2'b01; ac = 4'b0110; pe = (o == OP_BEQ) ? z : ~z; end
            P_ADDIWB:           rw = 1;
            P_JUMP:             begin ps = 2'b10; pe = 1; end
            default: ;
        endcase
        return {pe, io, mw, irw, rw, m2r, rd, sa, sb, ps, ac, il, 4'(ph)};
    endfunction

    // Runs one instruction (or its first max_cycles cycles when nonzero).
    // fw/mw: cycles mem_ready stays low in FETCH / in MEMRD-MEMWR.
    task automatic run_instr(input int d, input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int fw, input int mw, input int max_cycles);
        int   q[$];
        bit   ill, wen, mem_ph;
        int   ph, waits, cyc;
        logic rdy, rdy_eff;
        wen = (d == 0);
        ill = 0;
        cyc = 0;
        q.push_back(P_FETCH);
        q.push_back(P_DECODE);
        case (o)
            OP_LW:   begin q.push_back(P_MEMADR); q.push_back(P_MEMRD); q.push_back(P_MEMWB); end
            OP_SW:   begin q.push_back(P_MEMADR); q.push_back(P_MEMWR); end
            OP_R:    begin
                q.push_back(P_EXEC); q.push_back(P_ALUWB);
                ill = !(f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
            end
            OP_BEQ:  q.push_back(P_BRANCH);
            OP_BNE:  if (d == 0) q.push_back(P_BRANCH); else ill = 1;
            OP_ADDI: begin q.push_back(P_ADDIEX); q.push_back(P_ADDIWB); end
            OP_J:    q.push_back(P_JUMP);
            default: ill = 1;
        endcase
        foreach (q[i]) begin
            ph     = q[i];
            mem_ph = (ph == P_FETCH) || (ph == P_MEMRD) || (ph == P_MEMWR);
            waits  = 0;
            if (wen && ph == P_FETCH) waits = fw;
            else if (wen && mem_ph)   waits = mw;
            for (int c = 0; c <= waits; c++) begin
                @(posedge clk); #1;
                reset[d] = 1'b1;
                op[d]    = o;
                funct[d] = f;
                rdy      = (wen && mem_ph) ? 1'(c == waits) : 1'($urandom_range(0, 1));
                mem_ready[d] = rdy;
                zero[d]  = (ph == P_BRANCH) ? z : 1'($urandom_range(0, 1));
                rdy_eff  = wen ? rdy : 1'b1;
                @(negedge clk);
                check($sformatf("d%0d_op%b_%s", d, o, pname[ph]), 32'(obs(d)),
                      32'(expect_vec(ph, o, f, z, rdy_eff, ill)));
                cyc++;
                if (max_cycles != 0 && cyc >= max_cycles) return;
            end
        end
    endtask

    task automatic hold_reset_check(input int d, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            reset[d]     = 1'b0;
            mem_ready[d] = 1'($urandom_range(0, 1));
            op[d]        = 6'($urandom);
            @(negedge clk);
            check($sformatf("d%0d_reset_hold", d), 32'(obs(d)),
                  32'(expect_vec(P_FETCH, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0)));
        end
    endtask

    task automatic random_run(input int d, input int n);
        logic [5:0] ops [8];
        logic [5:0] fns [5];
        logic [5:0] o, f;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int k = 0; k < n; k++) begin
            o = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) o = 6'($urandom);
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(d, o, f, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            reset[d] = 1'b0; op[d] = '0; funct[d] = '0; zero[d] = 1'b0; mem_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++)
            check($sformatf("d%0d_reset_state", d), 32'(obs(d)),
                  32'(expect_vec(P_FETCH, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0)));

        // Instance 0: waits enabled, bne supported
        run_instr(0, OP_R,    6'b100000, 0, 1, 0, 0);
        run_instr(0, OP_LW,   6'd0,      0, 0, 2, 0);
        run_instr(0, OP_SW,   6'd0,      0, 0, 1, 0);
        run_instr(0, OP_BEQ,  6'd0,      1, 0, 0, 0);
        run_instr(0, OP_BNE,  6'd0,      1, 0, 0, 0);
        run_instr(0, OP_BNE,  6'd0,      0, 0, 0, 0);
        run_instr(0, 6'b111111, 6'd0,    0, 0, 0, 0);
        run_instr(0, OP_J,    6'd0,      0, 2, 0, 0);
        run_instr(0, OP_ADDI, 6'd0,      0, 0, 0, 0);
        run_instr(0, OP_R,    6'b101010, 0, 0, 0, 0);
        run_instr(0, OP_R,    6'b111000, 0, 0, 0, 0);

        // Reset mid-MEMWR: strobes drop at once, state returns to FETCH
        run_instr(0, OP_SW, 6'd0, 0, 0, 5, 4);
        #1;
        reset[0] = 1'b0;
        #1;
        check("d0_rst_async_mem_write", 32'(mem_write[0]), 32'd0);
        check("d0_rst_async_state", 32'(state_dbg[0]), 32'd0);
        mem_ready[0] = 1'b1;
        #1;
        check("d0_rst_async_vec", 32'(obs(0)), 32'(expect_vec(P_FETCH, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0)));
        hold_reset_check(0, 3);
        run_instr(0, OP_LW, 6'd0, 0, 0, 0, 0);
        random_run(0, 120);

        // Instance 1: waits ignored, bne illegal, 4-bit ALU control
        reset[0] = 1'b0;
        run_instr(1, OP_R,    6'b100000, 0, 0, 0, 0);
        run_instr(1, OP_R,    6'b100100, 0, 0, 0, 0);
        run_instr(1, OP_BNE,  6'd0,      1, 0, 0, 0);
        run_instr(1, OP_BEQ,  6'd0,      0, 0, 0, 0);
        run_instr(1, OP_LW,   6'd0,      0, 0, 0, 0);
        run_instr(1, OP_SW,   6'd0,      0, 0, 0, 0);
        run_instr(1, OP_J,    6'd0,      0, 0, 0, 0);
        random_run(1, 120);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
